alu_mult_seq: RTL

//  Multi-cycle MULT/MULTU sequencer that time-shares the pipeline's single 32-bit ALU.
//  It computes 32x32->64 products with a shift-add loop, using one ALU add/sub per cycle.

---
 rtl/alu_mult_seq.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/alu_mult_seq.sv
// Sequential 32x32->64 MULT/MULTU unit that borrows the pipeline's shared ALU
// for one add/sub per cycle and writes the product into HI/LO.
module alu_mult_seq #(
   parameter int         WIDTH  = 32,
   parameter logic [3:0] ADD_OP = 4'b0000,
   parameter logic [3:0] SUB_OP = 4'b0001
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cancel,
   input  logic [1:0]       hilo_we,
   input  logic [WIDTH-1:0] hilo_wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             alu_sel,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_NEG_A,
      S_NEG_B,
      S_LOOP,
      S_NEG_LO,
      S_NEG_HI,
      S_DONE
   } state_t;

   localparam logic [4:0] CNT_LAST = 5'(WIDTH - 1);

   state_t           state_reg;
   logic [WIDTH-1:0] mcand_reg;
   logic [WIDTH-1:0] phi_reg;
   logic [WIDTH-1:0] plo_reg;
   logic [4:0]       cnt_reg;
   logic             neg_reg;
   logic             sgn_reg;
   logic             z_reg;
   logic [WIDTH-1:0] hi_reg;
   logic [WIDTH-1:0] lo_reg;
   logic             busy_reg;
   logic             alu_sel_reg;
   logic             done_reg;
   logic             carry;

   // ALU operands depend only on registered state, so the loop through the
   // shared ALU is register -> ALU -> register within one cycle.
   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = ADD_OP;
      case (state_reg)
         S_NEG_A: begin
            alu_b  = mcand_reg;
            alu_op = SUB_OP;
         end
         S_NEG_B: begin
            alu_b  = plo_reg;
            alu_op = SUB_OP;
         end
         S_LOOP: begin
            alu_a = phi_reg;
            alu_b = plo_reg[0] ? mcand_reg : '0;
         end
         S_NEG_LO: begin
            alu_b  = plo_reg;
            alu_op = SUB_OP;
         end
         S_NEG_HI: begin
            alu_a = ~phi_reg;
            alu_b = {{(WIDTH-1){1'b0}}, z_reg};
         end
         default: ;
      endcase
   end

   // A wrapped sum is smaller than either addend; that is the carry out.
   assign carry = (alu_result < phi_reg);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         mcand_reg   <= '0;
         phi_reg     <= '0;
         plo_reg     <= '0;
         cnt_reg     <= '0;
         neg_reg     <= 1'b0;
         sgn_reg     <= 1'b0;
         z_reg       <= 1'b0;
         hi_reg      <= '0;
         lo_reg      <= '0;
         busy_reg    <= 1'b0;
         alu_sel_reg <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  mcand_reg   <= op_a;
                  phi_reg     <= '0;
                  plo_reg     <= op_b;
                  cnt_reg     <= '0;
                  sgn_reg     <= signed_op;
                  neg_reg     <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                  state_reg   <= signed_op ? S_NEG_A : S_LOOP;
                  busy_reg    <= 1'b1;
                  alu_sel_reg <= 1'b1;
               end else begin
                  if (hilo_we[1]) hi_reg <= hilo_wdata;
                  if (hilo_we[0]) lo_reg <= hilo_wdata;
               end
            end
            S_NEG_A: begin
               if (mcand_reg[WIDTH-1]) mcand_reg <= alu_result;
               state_reg <= S_NEG_B;
            end
            S_NEG_B: begin
               if (plo_reg[WIDTH-1]) plo_reg <= alu_result;
               state_reg <= S_LOOP;
            end
            S_LOOP: begin
               phi_reg <= {carry, alu_result[WIDTH-1:1]};
               plo_reg <= {alu_result[0], plo_reg[WIDTH-1:1]};
               cnt_reg <= cnt_reg + 5'd1;
               if (cnt_reg == CNT_LAST) begin
                  if (sgn_reg) begin
                     state_reg <= S_NEG_LO;
                  end else begin
                     state_reg   <= S_DONE;
                     alu_sel_reg <= 1'b0;
                     done_reg    <= 1'b1;
                  end
               end
            end
            S_NEG_LO: begin
               z_reg <= (plo_reg == '0);
               if (neg_reg) plo_reg <= alu_result;
               state_reg <= S_NEG_HI;
            end
            S_NEG_HI: begin
               if (neg_reg) phi_reg <= alu_result;
               state_reg   <= S_DONE;
               alu_sel_reg <= 1'b0;
               done_reg    <= 1'b1;
            end
            S_DONE: begin
               hi_reg    <= phi_reg;
               lo_reg    <= plo_reg;
               state_reg <= S_IDLE;
               busy_reg  <= 1'b0;
            end
            default: begin
               state_reg   <= S_IDLE;
               busy_reg    <= 1'b0;
               alu_sel_reg <= 1'b0;
            end
         endcase

         // A flush overrides the transition above; in DONE the HI/LO commit still lands.
         if (cancel && (state_reg != S_IDLE)) begin
            state_reg   <= S_IDLE;
            busy_reg    <= 1'b0;
            alu_sel_reg <= 1'b0;
            done_reg    <= 1'b0;
         end
      end
   end

   assign busy    = busy_reg;
   assign alu_sel = alu_sel_reg;
   assign done    = done_reg & ~cancel;
   assign hi      = hi_reg;
   assign lo      = lo_reg;

endmodule
